// File: rtl/bfs_pkg.sv
// Shared types and constants for the BFS queue spill/refill controller.
package bfs_pkg;

  localparam int unsigned BFS_WORD_W     = 32;
  localparam int unsigned BFS_WORD_BYTES = 4;

  // Controller states: one memory transaction in flight at most.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_PUSH = 3'd4
  } bfs_state_e;

endpackage

// File: rtl/bfs_spill_ctrl.sv
// Spills out-queue entries into a memory ring and refills the in-queue from it,
// preserving FIFO order. Refill takes priority over spill whenever both can run.
module bfs_spill_ctrl
  import bfs_pkg::*;
#(
  parameter int unsigned SPILL_DEPTH = 1024,
  parameter int unsigned ADDR_W      = 32,
  localparam int unsigned PTR_W      = $clog2(SPILL_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  bfs_rst_n,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  outq_empty,
  input  logic [BFS_WORD_W-1:0] outq_data,
  output logic                  outq_deq,
  input  logic                  inq_full,
  output logic                  inq_enq,
  output logic [BFS_WORD_W-1:0] inq_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [BFS_WORD_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [BFS_WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]      spill_count,
  output logic                  idle
);

  localparam int unsigned ADDR_SHIFT = $clog2(BFS_WORD_BYTES);

  bfs_state_e            r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [BFS_WORD_W-1:0] r_wdata;
  logic [BFS_WORD_W-1:0] r_inq_data;

  logic                  w_can_rd;
  logic                  w_can_wr;
  logic [PTR_W-1:0]      w_ptr;

  // Eligibility of a refill or a spill while idle.
  assign w_can_rd = (r_count != '0) && !inq_full;
  assign w_can_wr = !outq_empty && (r_count != CNT_W'(SPILL_DEPTH));

  // Address source: write pointer during a write, read pointer otherwise.
  assign w_ptr    = (r_state == ST_WR_REQ) ? r_wr_ptr : r_rd_ptr;
  assign mem_addr = base_addr + (ADDR_W'(w_ptr) << ADDR_SHIFT);

  // Handshake outputs decoded from the state register; dequeue follows the grant.
  assign mem_req     = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
  assign mem_we      = (r_state == ST_WR_REQ);
  assign outq_deq    = (r_state == ST_WR_REQ) && mem_gnt;
  assign inq_enq     = (r_state == ST_RD_PUSH);
  assign idle        = (r_state == ST_IDLE);
  assign mem_wdata   = r_wdata;
  assign inq_data    = r_inq_data;
  assign spill_count = r_count;

  // FSM with ring pointers, occupancy count and data registers.
  always_ff @(posedge clk or negedge bfs_rst_n) begin
    if (!bfs_rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wdata    <= '0;
      r_inq_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_can_rd) begin
            r_state <= ST_RD_REQ;
          end else if (w_can_wr) begin
            r_wdata <= outq_data;
            r_state <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (mem_gnt) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(1);
            r_state  <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (mem_gnt) begin
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            r_inq_data <= mem_rdata;
            r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
            r_count    <= r_count - CNT_W'(1);
            r_state    <= ST_RD_PUSH;
          end
        end
        ST_RD_PUSH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_spill_ctrl.sv
// Directed bench for bfs_spill_ctrl with a 4-entry spill ring.
module tb_bfs_spill_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        bfs_rst_n;
  logic [31:0] base_addr;
  logic        outq_empty;
  logic [31:0] outq_data;
  logic        outq_deq;
  logic        inq_full;
  logic        inq_enq;
  logic [31:0] inq_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [2:0]  spill_count;
  logic        idle;

  int checks;
  int errors;

  // Bench-side out-queue, memory ring and transaction recorders.
  logic [31:0] outq[$];
  logic [31:0] tmem[4];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] enq_q[$];
  int          n_deq;
  int          n_overlap;
  logic        gnt_en;
  logic        rv_en;
  logic        rd_pend;
  logic [1:0]  rd_idx;
  logic        s_req, s_we, s_deq, s_enq;
  logic [31:0] s_addr, s_wdata;

  bfs_spill_ctrl #(.SPILL_DEPTH(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .bfs_rst_n  (bfs_rst_n),
    .base_addr  (base_addr),
    .outq_empty (outq_empty),
    .outq_data  (outq_data),
    .outq_deq   (outq_deq),
    .inq_full   (inq_full),
    .inq_enq    (inq_enq),
    .inq_data   (inq_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .spill_count(spill_count),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic clear_rec();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    enq_q.delete();
    n_deq = 0;
  endtask

  // One clock: drive inputs mid-cycle, sample, record transactions, advance.
  task automatic cycle();
    outq_empty = (outq.size() == 0);
    outq_data  = outq_empty ? 32'h0 : outq[0];
    mem_gnt    = gnt_en;
    mem_rvalid = rd_pend && rv_en;
    mem_rdata  = tmem[rd_idx];
    #1;
    s_req = mem_req; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    s_deq = outq_deq; s_enq = inq_enq;
    if (mem_req && mem_gnt && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      tmem[2'((mem_addr - base_addr) >> 2)] = mem_wdata;
    end
    if (outq_deq) n_deq++;
    if (inq_enq) enq_q.push_back(inq_data);
    if (outq_deq && inq_enq) n_overlap++;
    if (mem_rvalid) rd_pend = 1'b0;
    if (mem_req && mem_gnt && !mem_we) begin
      rd_addr_q.push_back(mem_addr);
      rd_pend = 1'b1;
      rd_idx  = 2'((mem_addr - base_addr) >> 2);
    end
    @(posedge clk);
    if (s_deq) outq.delete(0);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b want 1", idle); end
    checks++; if (mem_req !== 1'b0 || outq_deq !== 1'b0 || inq_enq !== 1'b0) begin
      errors++; $display("FAIL rst_strobes got req=%0b deq=%0b enq=%0b want 0", mem_req, outq_deq, inq_enq); end
    checks++; if (mem_addr !== BASE) begin errors++; $display("FAIL rst_addr got %h want %h", mem_addr, BASE); end
    checks++; if (spill_count !== 3'd0 || inq_data !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_regs got cnt=%0d inq=%h wd=%h want 0", spill_count, inq_data, mem_wdata); end
    @(negedge clk);
    bfs_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_spill();
    logic [31:0] ea[2];
    logic [31:0] ed[2];
    ea = '{BASE, BASE + 32'h4};
    ed = '{32'hA1, 32'hA2};
    clear_rec();
    inq_full = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
    outq.push_back(32'hA1); outq.push_back(32'hA2);
    repeat (4) cycle();
    checks++; if (spill_count !== 3'd2) begin errors++; $display("FAIL spill_latency_cnt got %0d want 2", spill_count); end
    repeat (4) cycle();
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL spill_nwr got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
        errors++; $display("FAIL spill_wr%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]); end
    end
    checks++; if (n_deq != 2) begin errors++; $display("FAIL spill_deq got %0d want 2", n_deq); end
    checks++; if (idle !== 1'b1 || enq_q.size() != 0) begin
      errors++; $display("FAIL spill_end got idle=%0b enq=%0d want 1/0", idle, enq_q.size()); end
  endtask

  task automatic test_refill();
    logic [31:0] ea[2];
    logic [31:0] ed[2];
    ea = '{BASE, BASE + 32'h4};
    ed = '{32'hA1, 32'hA2};
    clear_rec();
    inq_full = 1'b0;
    repeat (8) cycle();
    checks++; if (spill_count !== 3'd0) begin errors++; $display("FAIL refill_cnt got %0d want 0", spill_count); end
    checks++; if (rd_addr_q.size() != 2 || enq_q.size() != 2) begin
      errors++; $display("FAIL refill_n got rd=%0d enq=%0d want 2/2", rd_addr_q.size(), enq_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_addr_q[i] !== ea[i] || enq_q[i] !== ed[i]) begin
        errors++; $display("FAIL refill_rd%0d got %h/%h want %h/%h", i, rd_addr_q[i], enq_q[i], ea[i], ed[i]); end
    end
    repeat (2) cycle();
    checks++; if (idle !== 1'b1 || rd_addr_q.size() != 2) begin
      errors++; $display("FAIL refill_empty_noread got idle=%0b rd=%0d want 1/2", idle, rd_addr_q.size()); end
  endtask

  task automatic test_stall();
    clear_rec();
    inq_full = 1'b1; gnt_en = 1'b0;
    outq.push_back(32'hB1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== BASE + 32'h8 || s_wdata !== 32'hB1 || s_deq !== 1'b0) begin
        errors++; $display("FAIL stall_c%0d got req=%0b a=%h wd=%h deq=%0b want 1/%h/000000b1/0",
                            i, s_req, s_addr, s_wdata, s_deq, BASE + 32'h8); end
    end
    gnt_en = 1'b1;
    cycle();
    checks++; if (s_deq !== 1'b1 || s_addr !== BASE + 32'h8) begin
      errors++; $display("FAIL stall_gnt got deq=%0b a=%h want 1/%h", s_deq, s_addr, BASE + 32'h8); end
    checks++; if (spill_count !== 3'd1 || n_deq != 1) begin
      errors++; $display("FAIL stall_end got cnt=%0d deq=%0d want 1/1", spill_count, n_deq); end
  endtask

  task automatic test_priority();
    clear_rec();
    inq_full = 1'b0;
    outq.push_back(32'hC1);
    cycle();
    cycle();
    checks++; if (s_req !== 1'b1 || s_we !== 1'b0 || s_addr !== BASE + 32'h8) begin
      errors++; $display("FAIL prio_first got req=%0b we=%0b a=%h want 1/0/%h", s_req, s_we, s_addr, BASE + 32'h8); end
    repeat (10) cycle();
    checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== BASE + 32'hC) begin
      errors++; $display("FAIL prio_wr got n=%0d a=%h want 1/%h", wr_addr_q.size(), wr_addr_q[0], BASE + 32'hC); end
    checks++; if (rd_addr_q.size() != 2 || rd_addr_q[1] !== BASE + 32'hC) begin
      errors++; $display("FAIL prio_rd got n=%0d a=%h want 2/%h", rd_addr_q.size(), rd_addr_q[1], BASE + 32'hC); end
    checks++; if (enq_q.size() != 2 || enq_q[0] !== 32'hB1 || enq_q[1] !== 32'hC1) begin
      errors++; $display("FAIL prio_order got n=%0d %h %h want 2 b1 c1", enq_q.size(), enq_q[0], enq_q[1]); end
    checks++; if (spill_count !== 3'd0) begin errors++; $display("FAIL prio_cnt got %0d want 0", spill_count); end
  endtask

  task automatic test_wrap_full();
    logic [31:0] ea[6];
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE, BASE + 32'h4};
    clear_rec();
    inq_full = 1'b1;
    for (int i = 1; i <= 6; i++) outq.push_back(32'hD0 + 32'(i));
    repeat (8) cycle();
    checks++; if (spill_count !== 3'd4 || wr_addr_q.size() != 4) begin
      errors++; $display("FAIL wrap_fill got cnt=%0d nwr=%0d want 4/4", spill_count, wr_addr_q.size()); end
    repeat (4) cycle();
    checks++; if (wr_addr_q.size() != 4 || s_req !== 1'b0 || outq.size() != 2 || spill_count !== 3'd4) begin
      errors++; $display("FAIL full_nowrite got nwr=%0d req=%0b outq=%0d cnt=%0d want 4/0/2/4",
                          wr_addr_q.size(), s_req, outq.size(), spill_count); end
    inq_full = 1'b0;
    repeat (8) cycle();
    inq_full = 1'b1;
    checks++; if (enq_q.size() != 2 || enq_q[0] !== 32'hD1 || enq_q[1] !== 32'hD2 || spill_count !== 3'd2) begin
      errors++; $display("FAIL wrap_refill2 got n=%0d %h %h cnt=%0d want 2 d1 d2 2",
                          enq_q.size(), enq_q[0], enq_q[1], spill_count); end
    repeat (4) cycle();
    checks++; if (wr_addr_q.size() != 6) begin errors++; $display("FAIL wrap_nwr got %0d want 6", wr_addr_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== 32'hD0 + 32'(i + 1)) begin
        errors++; $display("FAIL wrap_wr%0d got %h/%h want %h/%h", i, wr_addr_q[i], wr_data_q[i], ea[i], 32'hD0 + 32'(i + 1)); end
    end
    inq_full = 1'b0;
    repeat (16) cycle();
    checks++; if (enq_q.size() != 6 || spill_count !== 3'd0 || n_deq != 6) begin
      errors++; $display("FAIL wrap_drain got n=%0d cnt=%0d deq=%0d want 6/0/6", enq_q.size(), spill_count, n_deq); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rd_addr_q[i] !== ea[i] || enq_q[i] !== 32'hD0 + 32'(i + 1)) begin
        errors++; $display("FAIL wrap_rd%0d got %h/%h want %h/%h", i, rd_addr_q[i], enq_q[i], ea[i], 32'hD0 + 32'(i + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_rec();
    inq_full = 1'b1;
    outq.push_back(32'hE1);
    repeat (2) cycle();
    inq_full = 1'b0; rv_en = 1'b0;
    repeat (3) cycle();
    checks++; if (idle !== 1'b0 || spill_count !== 3'd1) begin
      errors++; $display("FAIL mid_pre got idle=%0b cnt=%0d want 0/1", idle, spill_count); end
    bfs_rst_n = 1'b0;
    #1;
    checks++; if (idle !== 1'b1 || mem_req !== 1'b0 || spill_count !== 3'd0 || mem_wdata !== 32'h0 || mem_addr !== BASE) begin
      errors++; $display("FAIL mid_rst got idle=%0b req=%0b cnt=%0d wd=%h a=%h want 1/0/0/0/%h",
                          idle, mem_req, spill_count, mem_wdata, mem_addr, BASE); end
    @(posedge clk);
    #1;
    bfs_rst_n = 1'b1;
    rv_en = 1'b1;
    repeat (4) cycle();
    checks++; if (enq_q.size() != 0 || spill_count !== 3'd0 || idle !== 1'b1 || inq_data !== 32'h0) begin
      errors++; $display("FAIL mid_late_rvalid got enq=%0d cnt=%0d idle=%0b inq=%h want 0/0/1/0",
                          enq_q.size(), spill_count, idle, inq_data); end
    inq_full = 1'b1;
    outq.push_back(32'hF1);
    repeat (3) cycle();
    checks++; if (wr_addr_q.size() != 2 || wr_addr_q[1] !== BASE || spill_count !== 3'd1) begin
      errors++; $display("FAIL mid_ptr_clr got n=%0d a=%h cnt=%0d want 2/%h/1", wr_addr_q.size(), wr_addr_q[1], spill_count, BASE); end
    checks++; if (n_overlap != 0) begin errors++; $display("FAIL deq_enq_overlap got %0d want 0", n_overlap); end
  endtask

  initial begin
    clk = 1'b0; bfs_rst_n = 1'b0; base_addr = BASE;
    outq_empty = 1'b1; outq_data = '0; inq_full = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    checks = 0; errors = 0; n_overlap = 0; n_deq = 0;
    gnt_en = 1'b1; rv_en = 1'b1; rd_pend = 1'b0; rd_idx = '0;
    for (int i = 0; i < 4; i++) tmem[i] = '0;
    test_reset();
    test_spill();
    test_refill();
    test_stall();
    test_priority();
    test_wrap_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfs_spill_ctrl.md
BFS_SPILL_CTRL -- requirements
Module: bfs_spill_ctrl

Interface
REQ-001 SHALL have parameter SPILL_DEPTH, default 1024, memory spill-ring capacity in 32-bit entries, power of two.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- bfs_rst_n  in  1  async active-low reset.
- base_addr  in  ADDR_W  byte base of spill ring, word aligned, static while not idle.
- outq_empty  in  1  out-queue empty.
- outq_data  in  32  out-queue head entry.
- outq_deq  out  1  pop out-queue head.
- inq_full  in  1  in-queue full.
- inq_enq  out  1  push inq_data into in-queue.
- inq_data  out  32  entry refilled from memory.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  request byte address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- spill_count  out  log2(SPILL_DEPTH)+1  entries held in memory.
- idle  out  1  FSM in IDLE.

Function
REQ-005 SHALL keep ring pointers wr_ptr, rd_ptr (log2(SPILL_DEPTH) bits, wrap modulo SPILL_DEPTH) and spill_count 0..SPILL_DEPTH.
REQ-006 SHALL form mem_addr = base_addr + (ptr << 2), truncated to ADDR_W.
REQ-007 SHALL implement FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_PUSH.
REQ-008 In IDLE, fill has priority: if spill_count != 0 and !inq_full, go to RD_REQ; else if !outq_empty and spill_count != SPILL_DEPTH, latch outq_data into mem_wdata and go to WR_REQ; else stay.
REQ-009 WR_REQ: mem_req=1, mem_we=1, mem_addr from wr_ptr; on mem_gnt, pulse outq_deq that same cycle, increment wr_ptr and spill_count, return to IDLE.
REQ-010 RD_REQ: mem_req=1, mem_we=0, mem_addr from rd_ptr; on mem_gnt, go to RD_WAIT.
REQ-011 RD_WAIT: on mem_rvalid, register mem_rdata into inq_data, increment rd_ptr, decrement spill_count, go to RD_PUSH.
REQ-012 RD_PUSH: inq_enq=1 for exactly one cycle, then IDLE; space is guaranteed because this block is the in-queue's only producer and inq_full was sampled low before RD_REQ.
REQ-013 Request outputs (mem_addr, mem_we, mem_wdata) SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-014 SHALL allow at most one outstanding memory transaction; mem_rvalid outside RD_WAIT is ignored.
REQ-015 SHALL preserve FIFO order: entries are refilled in the order they were spilled.
REQ-016 outq_deq and inq_enq SHALL never be asserted in the same cycle; each is a single-cycle pulse.
REQ-017 At spill_count == SPILL_DEPTH, SHALL issue no write; at spill_count == 0, SHALL issue no read.
REQ-018 Minimum cycle counts: spill = 2 cycles (IDLE, WR_REQ with immediate grant); refill = 4 cycles (IDLE, RD_REQ, RD_WAIT with immediate rvalid, RD_PUSH).
REQ-019 idle SHALL be 1 exactly in IDLE.

Reset
REQ-020 Asserting bfs_rst_n low SHALL immediately force IDLE and clear wr_ptr, rd_ptr, spill_count, inq_data, and mem_wdata.
REQ-021 During reset, mem_req, outq_deq, and inq_enq SHALL be 0, and mem_addr SHALL equal base_addr.
REQ-022 A reset mid-transaction SHALL discard in-flight data; a late mem_rvalid after reset is ignored per REQ-014.

Structure
REQ-023 A shared package bfs_pkg SHALL hold the FSM state enum, BFS_WORD_W=32, and BFS_WORD_BYTES=4.
REQ-024 The block SHALL be a single module with no sub-modules; pointer and counter logic stays inline.

Verification
REQ-025 Spill with immediate grant: outq holds 0xA1, 0xA2, spill empty, inq_full=1 -> two writes at base_addr+0 and +4, two outq_deq pulses, spill_count=2.
REQ-026 Refill in order: spill_count=2, then inq_full=0 -> reads at +0 then +4, inq_data 0xA1 then 0xA2, one inq_enq pulse each, spill_count=0.
REQ-027 Grant stall: mem_gnt held low 5 cycles during WR_REQ -> mem_addr and mem_wdata stable, outq_deq only in the grant cycle.
REQ-028 Wrap and full, SPILL_DEPTH=4: 6 spills interleaved with 2 refills -> 5th write goes to base_addr+0; with count=4, no write is issued even while outq is non-empty.
REQ-029 Priority: spill_count=1, inq not full, outq not empty, both eligible in IDLE -> read issued first.
REQ-030 Reset in RD_WAIT, then mem_rvalid one cycle after release -> no inq_enq, spill_count=0, idle=1.
